step_down_counter: RTL and testbench
====================================

// Module: step_down_counter
//
// PURPOSE
//   Consumer-side counterpart to the step-up register tasks: accepts a load value through a
//   valid/ready handshake, then counts it down by STEP per un-paused cycle until it reaches zero.
//   Reports completion with a one-cycle done pulse and flags a non-zero remainder as underflow.
//   Sits behind any block that hands off a budget or credit count to be drained at a fixed rate.
//
// PARAMETERS
//   WIDTH  8  bit width of load_value and count
//   STEP   3  decrement per active cycle; legal range 1..2^WIDTH-1 (STEP=0 is illegal)
//
// PORTS
//   clock       input   1      single clock, all state updates on posedge
//   reset_n     input   1      synchronous reset, active-low
//   load_valid  input   1      load_value is valid this cycle
//   load_ready  output  1      block can accept a load this cycle
//   load_value  input   WIDTH  starting count, captured on handshake
//   pause       input   1      hold count in RUN (no effect in IDLE/DONE)
//   count       output  WIDTH  current remaining count (registered)
//   busy        output  1      high in RUN
//   done        output  1      one-cycle pulse on entry to DONE
//   underflow   output  1      qualifies done: final step exceeded remaining count
//
// BEHAVIOUR
//   Clocking/reset: one clock; reset is synchronous and active-low.
//   Reset: state=IDLE, count=0, busy=0, done=0, underflow=0, load_ready=1.
//   Reset has priority over every other input, in every state.
//   States:
//     IDLE: load_ready=1. On load_valid&&load_ready: count<=load_value;
//           load_value==0 -> DONE (underflow<=0); else -> RUN.
//     RUN:  load_ready=0, busy=1. pause=1: hold count and state.
//           pause=0 and count>STEP:  count<=count-STEP, stay RUN.
//           pause=0 and count==STEP: count<=0, underflow<=0, -> DONE.
//           pause=0 and count<STEP:  count<=0, underflow<=1, -> DONE.
//     DONE: load_ready=0, busy=0, done=1, underflow valid; exactly one cycle, then -> IDLE.
//           In IDLE, done=0 and underflow=0.
//   Outputs: done, underflow, busy and count are all registered, with no combinational path
//   from inputs. load_ready is decoded from state only, never from load_valid.
//   Latency: a load V>0 accepted at edge 0 makes done high in the cycle after edge
//   ceil(V/STEP) plus the number of paused RUN cycles.
//   A load V=0 makes done high in the cycle right after acceptance.
//   Arithmetic: all compares and subtracts are unsigned WIDTH-bit; count never wraps below 0.
//   Boundaries:
//     load_valid in RUN/DONE: ignored, nothing captured.
//     pause asserted in the same cycle as the final step: the step is held, no done.
//     Back-to-back loads: the next accept happens in the IDLE cycle after DONE, so the minimum
//     spacing is 2 cycles for V=0.
//     reset_n low mid-RUN: next cycle is IDLE with count=0, and no done pulse is emitted.
//
// TESTING
//   1. STEP=3, load 9: count 9,6,3,0; done in cycle 3 after accept; underflow=0; busy high 3 cycles.
//   2. STEP=3, load 10: count 10,7,4,1,0; done in cycle 4; underflow=1 with done, 0 after.
//   3. Load 0: no RUN; done=1, underflow=0 in the cycle after accept; load_ready=1 again next cycle.
//   4. Load 9, pause high for 2 cycles at count=6: count holds at 6; done delayed to cycle 5.
//   5. Load 9, drive reset_n=0 for one cycle at count=6: next cycle count=0, IDLE, load_ready=1,
//      and done never pulses.
//   6. Load 255, then hold load_valid=1 with value 7 throughout RUN: nothing captured;
//      done at cycle 85 with underflow=0; the value 7 is then accepted in IDLE.

Source files
------------

// File: rtl/step_down_counter.sv
// step_down_counter
// Accepts a starting count through a valid/ready handshake. It then drains that
// count by STEP on every un-paused cycle until the count reaches zero. When the
// count reaches zero, the block pulses done for one cycle. If the last step was
// larger than what remained, underflow is raised together with done.
//
// STEP must lie in 1..2^WIDTH-1. A STEP of zero would never drain the count.
module step_down_counter #(
   parameter int WIDTH = 8,
   parameter int STEP  = 3
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_value,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             underflow
);

   // Step size at counter width, so every compare and subtract is unsigned WIDTH-bit
   localparam logic [WIDTH-1:0] L_STEP = WIDTH'(STEP);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           r_state;
   state_t           w_stateNext;
   logic [WIDTH-1:0] r_count;
   logic [WIDTH-1:0] w_countNext;
   logic             r_busy;
   logic             r_done;
   logic             r_underflow;
   logic             w_underflowNext;
   logic             w_loadReady;
   logic             w_loadAccept;

   // Ready depends only on the current state. It is never decoded from load_valid.
   assign w_loadReady  = (r_state == ST_IDLE);
   assign w_loadAccept = load_valid && w_loadReady;

   // Next-state and next-count decode. A final step that overshoots clamps the count to zero and flags underflow.
   always_comb begin
      w_stateNext     = r_state;
      w_countNext     = r_count;
      w_underflowNext = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_loadAccept) begin
               w_countNext = load_value;
               if (load_value == '0) begin
                  w_stateNext = ST_DONE;
               end else begin
                  w_stateNext = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (!pause) begin
               if (r_count > L_STEP) begin
                  w_countNext = r_count - L_STEP;
               end else begin
                  w_countNext     = '0;
                  w_underflowNext = (r_count < L_STEP);
                  w_stateNext     = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            w_stateNext = ST_IDLE;
         end
         default: begin
            w_stateNext = ST_IDLE;
            w_countNext = '0;
         end
      endcase
   end

   // State, count and status flags are all registered. Reset takes priority over everything else.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state     <= ST_IDLE;
         r_count     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_count     <= w_countNext;
         r_busy      <= (w_stateNext == ST_RUN);
         r_done      <= (w_stateNext == ST_DONE);
         r_underflow <= w_underflowNext;
      end
   end

   assign load_ready = w_loadReady;
   assign count      = r_count;
   assign busy       = r_busy;
   assign done       = r_done;
   assign underflow  = r_underflow;

endmodule

// File: tb/tb_step_down_counter.sv
// Directed bench for step_down_counter with WIDTH=8 and STEP=3.
// Most cases come from a table of per-cycle vectors. Each vector holds the inputs for
// one cycle and the outputs expected just after the next rising edge. The long drain
// of 255 is written out by hand.
module tb_step_down_counter;

   typedef struct {
      logic       rstN;
      logic       loadValid;
      logic [7:0] loadValue;
      logic       pauseIn;
      logic [7:0] expCount;
      logic       expBusy;
      logic       expDone;
      logic       expUnderflow;
      logic       expReady;
   } vec_t;

   logic       clock;
   logic       reset_n;
   logic       load_valid;
   logic       load_ready;
   logic [7:0] load_value;
   logic       pause;
   logic [7:0] count;
   logic       busy;
   logic       done;
   logic       underflow;

   int   checks;
   int   errors;
   vec_t vecs[$];

   step_down_counter #(.WIDTH(8), .STEP(3)) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .load_value (load_value),
      .pause      (pause),
      .count      (count),
      .busy       (busy),
      .done       (done),
      .underflow  (underflow)
   );

   // Free-running clock with a 10 ns period
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic applyStimulus(input logic rstN, input logic lv, input logic [7:0] val, input logic p);
      reset_n    = rstN;
      load_valid = lv;
      load_value = val;
      pause      = p;
   endtask

   task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("[TB] FAIL %s got %0d want %0d", name, got, want);
      end
   endtask

   task automatic checkAll(input string tag, input logic [7:0] c, input logic b, input logic d,
                           input logic u, input logic r);
      checkOutput({tag, " count"}, count, c);
      checkOutput({tag, " busy"}, {7'd0, busy}, {7'd0, b});
      checkOutput({tag, " done"}, {7'd0, done}, {7'd0, d});
      checkOutput({tag, " underflow"}, {7'd0, underflow}, {7'd0, u});
      checkOutput({tag, " load_ready"}, {7'd0, load_ready}, {7'd0, r});
   endtask

   task automatic stepCycle();
      @(posedge clock);
      #1;
   endtask

   function automatic void addVec(input logic rstN, input logic lv, input logic [7:0] val,
                                  input logic p, input logic [7:0] c, input logic b,
                                  input logic d, input logic u, input logic r);
      vec_t v;
      v.rstN = rstN; v.loadValid = lv; v.loadValue = val; v.pauseIn = p;
      v.expCount = c; v.expBusy = b; v.expDone = d; v.expUnderflow = u; v.expReady = r;
      vecs.push_back(v);
   endfunction

   initial begin
      checks = 0;
      errors = 0;

      // Load 9 drains exactly: 9, 6, 3, then 0 with done and no underflow
      addVec(1, 1, 8'd9,  0, 8'd9,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd6,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd3,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 1, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Load 10 overshoots on its last step: 10, 7, 4, 1, then 0 with underflow
      addVec(1, 1, 8'd10, 0, 8'd10, 1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd7,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd4,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd1,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 1, 1, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Load 0 goes straight to done. A load offered during DONE is ignored; the next 0 is accepted 2 cycles later.
      addVec(1, 1, 8'd0,  0, 8'd0,  0, 1, 0, 0);
      addVec(1, 1, 8'd5,  0, 8'd0,  0, 0, 0, 1);
      addVec(1, 1, 8'd0,  0, 8'd0,  0, 1, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Load 9 with two paused cycles at 6 holds the count and delays done to cycle 5
      addVec(1, 1, 8'd9,  0, 8'd9,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd6,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  1, 8'd6,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  1, 8'd6,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd3,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 1, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Pause during the final step holds it, so done does not fire until pause drops
      addVec(1, 1, 8'd3,  0, 8'd3,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  1, 8'd3,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 1, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Reset mid-RUN returns to IDLE with count 0 and never pulses done
      addVec(1, 1, 8'd9,  0, 8'd9,  1, 0, 0, 0);
      addVec(1, 0, 8'd0,  0, 8'd6,  1, 0, 0, 0);
      addVec(0, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      addVec(1, 0, 8'd0,  0, 8'd0,  0, 0, 0, 1);
      // Reset wins over a load offered in IDLE
      addVec(0, 1, 8'd9,  0, 8'd0,  0, 0, 0, 1);

      applyStimulus(0, 0, 8'd0, 0);
      stepCycle();
      stepCycle();
      checkAll("reset", 8'd0, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].rstN, vecs[i].loadValid, vecs[i].loadValue, vecs[i].pauseIn);
         stepCycle();
         checkAll($sformatf("vec%0d", i), vecs[i].expCount, vecs[i].expBusy,
                  vecs[i].expDone, vecs[i].expUnderflow, vecs[i].expReady);
      end

      // Load 255, then keep offering 7 throughout RUN; the 7 must not be captured until IDLE
      applyStimulus(1, 1, 8'd255, 0);
      stepCycle();
      checkAll("long load", 8'd255, 1, 0, 0, 0);
      applyStimulus(1, 1, 8'd7, 0);
      for (int k = 1; k <= 84; k++) begin
         stepCycle();
         checkOutput($sformatf("long run%0d count", k), count, 8'(255 - 3 * k));
         checkOutput($sformatf("long run%0d done", k), {7'd0, done}, 8'd0);
      end
      stepCycle();
      checkAll("long done", 8'd0, 0, 1, 0, 0);
      stepCycle();
      checkAll("long idle", 8'd0, 0, 0, 0, 1);
      stepCycle();
      checkAll("accept 7", 8'd7, 1, 0, 0, 0);
      applyStimulus(1, 0, 8'd0, 0);
      stepCycle();
      checkAll("seven a", 8'd4, 1, 0, 0, 0);
      stepCycle();
      checkAll("seven b", 8'd1, 1, 0, 0, 0);
      stepCycle();
      checkAll("seven done", 8'd0, 0, 1, 1, 0);
      stepCycle();
      checkAll("seven idle", 8'd0, 0, 0, 0, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
